// File: rtl/recog_pkg.sv
// Shared state type, default result codes and width helpers for the glyph recognizer.
package recog_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        MATCH,
        DONE
    } recog_state_t;

    localparam int BLANK_CODE_DEF  = 32;
    localparam int REJECT_CODE_DEF = 63;

    // Index width for n items; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width able to hold a count from 0 to n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/glyph_recognizer_row_popcount.sv
// Combinational popcount of one W-bit bitmap row (XOR against a template row upstream).
module row_popcount
    import recog_pkg::*;
#(
    parameter int W = 32,
    localparam int CW = cnt_w(W)
) (
    input  logic [W-1:0]  row_i,
    output logic [CW-1:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < W; i++) begin
            count_o = count_o + CW'(row_i[i]);
        end
    end

endmodule

// File: rtl/glyph_recognizer.sv
// Streams the canvas into a local bitmap, then picks the nearest template by Hamming distance.
// Optional bounding-box outputs are built when RECOG_BBOX_EN is defined.
module glyph_recognizer
    import recog_pkg::*;
#(
    parameter int W           = 32,
    parameter int H           = 32,
    parameter int NUM_T       = 26,
    parameter int CODE_BASE   = 65,
    parameter int BLANK_CODE  = BLANK_CODE_DEF,
    parameter int REJECT_CODE = REJECT_CODE_DEF,
    parameter int REJECT_DIST = 256,
    localparam int XW = idx_w(W),
    localparam int YW = idx_w(H),
    localparam int TW = idx_w(NUM_T),
    localparam int PA = idx_w(W * H),
    localparam int TA = idx_w(NUM_T * H),
    localparam int DW = cnt_w(W * H),
    localparam int RW = cnt_w(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          pix_rd_en,
    output logic [PA-1:0] pix_rd_addr,
    input  logic          pix_rd_data,
    output logic          tmpl_rd_en,
    output logic [TA-1:0] tmpl_rd_addr,
    input  logic [W-1:0]  tmpl_rd_data,
    output logic          busy,
    output logic          result_valid,
    input  logic          result_ready,
    output logic [7:0]    result_code,
    output logic [DW-1:0] result_dist
`ifdef RECOG_BBOX_EN
    ,
    output logic [XW-1:0] bbox_x0,
    output logic [XW-1:0] bbox_x1,
    output logic [YW-1:0] bbox_y0,
    output logic [YW-1:0] bbox_y1
`endif
);

    recog_state_t  state_q;
    logic          pix_en_q, pix_vld_q, tmpl_en_q, tmpl_vld_q, valid_q;
    logic [PA-1:0] pix_addr_q;
    logic [XW-1:0] pix_x_q, cap_x_q;
    logic [YW-1:0] pix_y_q, cap_y_q, r_q, sc_r_q;
    logic [TA-1:0] tmpl_addr_q;
    logic [TW-1:0] t_q, sc_t_q, best_idx_q, fin_idx_d;
    logic [DW-1:0] ones_q, run_q, best_q, tot_d, fin_best_d, dist_q, dist_d;
    logic [7:0]    code_q, code_d;
    logic [RW-1:0] row_dist;
    logic [W-1:0]  bitmap_q [H];
`ifdef RECOG_BBOX_EN
    logic [XW-1:0] bx0_q, bx1_q;
    logic [YW-1:0] by0_q, by1_q;
`endif

    row_popcount #(.W(W)) u_row_popcount (
        .row_i   (bitmap_q[sc_r_q] ^ tmpl_rd_data),
        .count_o (row_dist)
    );

    // Candidate best including the row being scored now, and the result it would produce.
    always_comb begin
        tot_d      = run_q + DW'(row_dist);
        fin_best_d = best_q;
        fin_idx_d  = best_idx_q;
        if (tot_d < best_q) begin
            fin_best_d = tot_d;
            fin_idx_d  = sc_t_q;
        end
        code_d = 8'(CODE_BASE + int'(fin_idx_d));
        dist_d = fin_best_d;
        if (ones_q == '0) begin
            code_d = 8'(BLANK_CODE);
            dist_d = '0;
        end else if (int'(fin_best_d) > REJECT_DIST) begin
            code_d = 8'(REJECT_CODE);
        end
    end

    always_ff @(posedge clk) begin
        if (pix_vld_q) begin
            bitmap_q[cap_y_q][cap_x_q] <= pix_rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pix_en_q    <= 1'b0;
            pix_vld_q   <= 1'b0;
            pix_addr_q  <= '0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            cap_x_q     <= '0;
            cap_y_q     <= '0;
            tmpl_en_q   <= 1'b0;
            tmpl_vld_q  <= 1'b0;
            tmpl_addr_q <= '0;
            t_q         <= '0;
            r_q         <= '0;
            sc_t_q      <= '0;
            sc_r_q      <= '0;
            ones_q      <= '0;
            run_q       <= '0;
            best_q      <= '0;
            best_idx_q  <= '0;
            valid_q     <= 1'b0;
            code_q      <= '0;
            dist_q      <= '0;
`ifdef RECOG_BBOX_EN
            bx0_q <= '0;
            bx1_q <= '0;
            by0_q <= '0;
            by1_q <= '0;
`endif
        end else begin
            pix_vld_q <= pix_en_q;
            cap_x_q   <= pix_x_q;
            cap_y_q   <= pix_y_q;
            if (pix_en_q) begin
                if (pix_addr_q == PA'(W * H - 1)) begin
                    pix_en_q    <= 1'b0;
                    tmpl_en_q   <= 1'b1;
                    tmpl_addr_q <= '0;
                    t_q         <= '0;
                    r_q         <= '0;
                end else begin
                    pix_addr_q <= pix_addr_q + 1'b1;
                    if (pix_x_q == XW'(W - 1)) begin
                        pix_x_q <= '0;
                        pix_y_q <= pix_y_q + 1'b1;
                    end else begin
                        pix_x_q <= pix_x_q + 1'b1;
                    end
                end
            end

            tmpl_vld_q <= tmpl_en_q;
            sc_t_q     <= t_q;
            sc_r_q     <= r_q;
            if (tmpl_en_q) begin
                if (tmpl_addr_q == TA'(NUM_T * H - 1)) begin
                    tmpl_en_q <= 1'b0;
                end else begin
                    tmpl_addr_q <= tmpl_addr_q + 1'b1;
                    if (r_q == YW'(H - 1)) begin
                        r_q <= '0;
                        t_q <= t_q + 1'b1;
                    end else begin
                        r_q <= r_q + 1'b1;
                    end
                end
            end

            // Pixel capture stage: count ones and track the bounding box.
            if (pix_vld_q) begin
                ones_q <= ones_q + DW'(pix_rd_data);
                if (cap_x_q == XW'(W - 1) && cap_y_q == YW'(H - 1)) begin
                    state_q <= MATCH;
                end
`ifdef RECOG_BBOX_EN
                if (pix_rd_data) begin
                    if (ones_q == '0) begin
                        bx0_q <= cap_x_q;
                        bx1_q <= cap_x_q;
                        by0_q <= cap_y_q;
                        by1_q <= cap_y_q;
                    end else begin
                        if (cap_x_q < bx0_q) bx0_q <= cap_x_q;
                        if (cap_x_q > bx1_q) bx1_q <= cap_x_q;
                        if (cap_y_q < by0_q) by0_q <= cap_y_q;
                        if (cap_y_q > by1_q) by1_q <= cap_y_q;
                    end
                end
`endif
            end

            // Scoring stage: accumulate row distances, close out each template at its last row.
            if (tmpl_vld_q) begin
                if (sc_r_q == YW'(H - 1)) begin
                    run_q      <= '0;
                    best_q     <= fin_best_d;
                    best_idx_q <= fin_idx_d;
                    if (sc_t_q == TW'(NUM_T - 1)) begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                        code_q  <= code_d;
                        dist_q  <= dist_d;
                    end
                end else begin
                    run_q <= tot_d;
                end
            end

            if (state_q == DONE && valid_q && result_ready) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
            end

            // A start in DONE drops the pending result and begins a fresh load.
            if (start && (state_q == IDLE || state_q == DONE)) begin
                state_q    <= LOAD;
                valid_q    <= 1'b0;
                pix_en_q   <= 1'b1;
                pix_addr_q <= '0;
                pix_x_q    <= '0;
                pix_y_q    <= '0;
                ones_q     <= '0;
                run_q      <= '0;
                best_q     <= '1;
                best_idx_q <= '0;
`ifdef RECOG_BBOX_EN
                bx0_q <= '0;
                bx1_q <= '0;
                by0_q <= '0;
                by1_q <= '0;
`endif
            end
        end
    end

    assign pix_rd_en    = pix_en_q;
    assign pix_rd_addr  = pix_addr_q;
    assign tmpl_rd_en   = tmpl_en_q;
    assign tmpl_rd_addr = tmpl_addr_q;
    assign busy         = (state_q == LOAD) || (state_q == MATCH);
    assign result_valid = valid_q;
    assign result_code  = code_q;
    assign result_dist  = dist_q;
`ifdef RECOG_BBOX_EN
    assign bbox_x0 = bx0_q;
    assign bbox_x1 = bx1_q;
    assign bbox_y0 = by0_q;
    assign bbox_y1 = by1_q;
`endif

endmodule

// File: tb/tb_glyph_recognizer.sv
// Directed bench for glyph_recognizer with behavioural canvas RAM and template ROM.
`timescale 1ns/1ps
module tb_glyph_recognizer;
    localparam int W = 32, H = 32, NT = 26, N = W * H, M = NT * H;

    logic        clk = 1'b0;
    logic        rst = 1'b1, start = 1'b0, result_ready = 1'b0;
    logic        pix_rd_en, tmpl_rd_en, busy, result_valid;
    logic        pix_rd_data = 1'b0;
    logic [9:0]  pix_rd_addr, tmpl_rd_addr;
    logic [31:0] tmpl_rd_data = '0;
    logic [7:0]  result_code;
    logic [10:0] result_dist;
`ifdef RECOG_BBOX_EN
    logic [4:0]  bbox_x0, bbox_x1, bbox_y0, bbox_y1;
`endif

    logic        canvas [N];
    logic [31:0] tmpl [M];
    int total = 0, bad = 0;

    int          lat;
    logic        s1_en, s1_busy, s1_valid, s1025_pen, s1025_ten, s1857_ten, s1857_valid;
    logic [9:0]  s1_addr, s1024_addr, s1025_taddr, s1856_taddr, smid_addr;

    glyph_recognizer dut (
        .clk(clk), .rst(rst), .start(start),
        .pix_rd_en(pix_rd_en), .pix_rd_addr(pix_rd_addr), .pix_rd_data(pix_rd_data),
        .tmpl_rd_en(tmpl_rd_en), .tmpl_rd_addr(tmpl_rd_addr), .tmpl_rd_data(tmpl_rd_data),
        .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
        .result_code(result_code), .result_dist(result_dist)
`ifdef RECOG_BBOX_EN
        , .bbox_x0(bbox_x0), .bbox_x1(bbox_x1), .bbox_y0(bbox_y0), .bbox_y1(bbox_y1)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pix_rd_en) pix_rd_data <= canvas[pix_rd_addr];
        if (tmpl_rd_en) tmpl_rd_data <= tmpl[tmpl_rd_addr];
    end

    // Template t, row r: single pixel at column (r+t) mod 32.
    task automatic init_tmpl();
        for (int t = 0; t < NT; t++)
            for (int r = 0; r < H; r++) tmpl[t*H+r] = 32'h1 << ((r + t) % 32);
    endtask

    task automatic canvas_from_tmpl(input int t);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) canvas[y*W+x] = tmpl[t*H+y][x];
    endtask

    task automatic canvas_clear();
        for (int a = 0; a < N; a++) canvas[a] = 1'b0;
    endtask

    task automatic add_extras(input int n);
        int c;
        c = 0;
        for (int a = 0; a < N; a++)
            if (c < n && !canvas[a]) begin canvas[a] = 1'b1; c++; end
    endtask

    // Pulses start (optionally with result_ready), then waits for result_valid with a bound.
    task automatic run(input int mid_k, input bit with_ready);
        @(negedge clk);
        start = 1'b1;
        result_ready = with_ready;
        @(posedge clk);
        lat = -1;
        for (int k = 1; k <= 3000; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0; result_ready = 1'b0;
                s1_en = pix_rd_en; s1_addr = pix_rd_addr; s1_busy = busy; s1_valid = result_valid;
            end
            if (mid_k > 0 && k == mid_k) start = 1'b1;
            if (mid_k > 0 && k == mid_k + 1) begin start = 1'b0; smid_addr = pix_rd_addr; end
            if (k == 1024) s1024_addr = pix_rd_addr;
            if (k == 1025) begin s1025_pen = pix_rd_en; s1025_ten = tmpl_rd_en; s1025_taddr = tmpl_rd_addr; end
            if (k == 1856) s1856_taddr = tmpl_rd_addr;
            if (k == 1857) begin s1857_ten = tmpl_rd_en; s1857_valid = result_valid; end
            if (result_valid) begin lat = k; break; end
        end
    endtask

    task automatic accept(output logic v_after);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        v_after = result_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (pix_rd_en !== 1'b0) begin bad++; $display("FAIL reset_pix_en: got %b want 0", pix_rd_en); end
        total++; if (pix_rd_addr !== 10'd0) begin bad++; $display("FAIL reset_pix_addr: got %0d want 0", pix_rd_addr); end
        total++; if (tmpl_rd_en !== 1'b0) begin bad++; $display("FAIL reset_tmpl_en: got %b want 0", tmpl_rd_en); end
        total++; if (tmpl_rd_addr !== 10'd0) begin bad++; $display("FAIL reset_tmpl_addr: got %0d want 0", tmpl_rd_addr); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", result_valid); end
        total++; if (result_code !== 8'd0) begin bad++; $display("FAIL reset_code: got %0d want 0", result_code); end
        total++; if (result_dist !== 11'd0) begin bad++; $display("FAIL reset_dist: got %0d want 0", result_dist); end
        rst = 1'b0;
    endtask

    task automatic test_template0();
        logic v;
        canvas_from_tmpl(0);
        run(0, 1'b0);
        total++; if (lat !== 1858) begin bad++; $display("FAIL t0_latency: got %0d want 1858", lat); end
        total++; if (s1_en !== 1'b1 || s1_addr !== 10'd0) begin bad++; $display("FAIL t0_first_read: got en=%b addr=%0d want en=1 addr=0", s1_en, s1_addr); end
        total++; if (s1_busy !== 1'b1) begin bad++; $display("FAIL t0_busy_load: got %b want 1", s1_busy); end
        total++; if (s1024_addr !== 10'd1023) begin bad++; $display("FAIL t0_last_pix_addr: got %0d want 1023", s1024_addr); end
        total++; if (s1025_pen !== 1'b0 || s1025_ten !== 1'b1 || s1025_taddr !== 10'd0) begin bad++; $display("FAIL t0_match_start: got pen=%b ten=%b taddr=%0d want 0 1 0", s1025_pen, s1025_ten, s1025_taddr); end
        total++; if (s1856_taddr !== 10'd831) begin bad++; $display("FAIL t0_last_tmpl_addr: got %0d want 831", s1856_taddr); end
        total++; if (s1857_ten !== 1'b0 || s1857_valid !== 1'b0) begin bad++; $display("FAIL t0_tail: got ten=%b valid=%b want 0 0", s1857_ten, s1857_valid); end
        total++; if (result_code !== 8'd65) begin bad++; $display("FAIL t0_code: got %0d want 65", result_code); end
        total++; if (result_dist !== 11'd0) begin bad++; $display("FAIL t0_dist: got %0d want 0", result_dist); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t0_busy_done: got %b want 0", busy); end
        accept(v);
        total++; if (v !== 1'b0) begin bad++; $display("FAIL t0_valid_drop: got %b want 0", v); end
    endtask

    task automatic test_template3_flipped();
        logic v;
        canvas_from_tmpl(3);
        canvas[0*W+0] = 1'b1; canvas[1*W+5] = 1'b1; canvas[2*W+10] = 1'b1;
        canvas[3*W+20] = 1'b1; canvas[4*W+31] = 1'b1;
        run(0, 1'b0);
        total++; if (result_code !== 8'd68 || result_dist !== 11'd5) begin bad++; $display("FAIL t3_flip: got code=%0d dist=%0d want 68 5", result_code, result_dist); end
        accept(v);
    endtask

    task automatic test_tie();
        logic v;
        for (int r = 0; r < H; r++) tmpl[7*H+r] = tmpl[2*H+r];
        tmpl[7*H+10] = tmpl[7*H+10] | 32'h0FF0_0000;
        canvas_from_tmpl(2);
        for (int x = 20; x < 24; x++) canvas[10*W+x] = 1'b1;
        run(0, 1'b0);
        total++; if (result_code !== 8'd67 || result_dist !== 11'd4) begin bad++; $display("FAIL tie_low_index: got code=%0d dist=%0d want 67 4", result_code, result_dist); end
        accept(v);
        init_tmpl();
    endtask

    task automatic test_blank_and_reject();
        logic v;
        int   nx [3];
        int   ec [3];
        nx = '{256, 257, 300};
        ec = '{65, 63, 63};
        canvas_clear();
        run(0, 1'b0);
        total++; if (result_code !== 8'd32 || result_dist !== 11'd0) begin bad++; $display("FAIL blank: got code=%0d dist=%0d want 32 0", result_code, result_dist); end
`ifdef RECOG_BBOX_EN
        total++; if ({bbox_x0, bbox_x1, bbox_y0, bbox_y1} !== 20'd0) begin bad++; $display("FAIL blank_bbox: got %h want 0", {bbox_x0, bbox_x1, bbox_y0, bbox_y1}); end
`endif
        accept(v);
        for (int i = 0; i < 3; i++) begin
            canvas_from_tmpl(0);
            add_extras(nx[i]);
            run(0, 1'b0);
            total++; if (result_code !== 8'(ec[i]) || result_dist !== 11'(nx[i])) begin bad++; $display("FAIL reject_%0d: got code=%0d dist=%0d want %0d %0d", nx[i], result_code, result_dist, ec[i], nx[i]); end
            accept(v);
        end
    endtask

    task automatic test_handshake_and_mid_start();
        canvas_from_tmpl(0);
        run(100, 1'b0);
        total++; if (smid_addr !== 10'd100) begin bad++; $display("FAIL mid_load_start: got addr=%0d want 100", smid_addr); end
        total++; if (lat !== 1858) begin bad++; $display("FAIL mid_load_latency: got %0d want 1858", lat); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++; if (result_valid !== 1'b1 || result_code !== 8'd65 || result_dist !== 11'd0) begin bad++; $display("FAIL hold_%0d: got valid=%b code=%0d dist=%0d want 1 65 0", i, result_valid, result_code, result_dist); end
        end
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL hold_drop: got %b want 0", result_valid); end
    endtask

    task automatic test_restart_in_done();
        logic v;
        canvas_from_tmpl(0);
        run(0, 1'b0);
        canvas_from_tmpl(5);
        run(0, 1'b0);
        total++; if (s1_valid !== 1'b0 || s1_busy !== 1'b1) begin bad++; $display("FAIL done_restart_drop: got valid=%b busy=%b want 0 1", s1_valid, s1_busy); end
        total++; if (lat !== 1858 || result_code !== 8'd70) begin bad++; $display("FAIL done_restart_result: got lat=%0d code=%0d want 1858 70", lat, result_code); end
        canvas_from_tmpl(9);
        run(0, 1'b1);
        total++; if (s1_valid !== 1'b0 || s1_busy !== 1'b1) begin bad++; $display("FAIL accept_start_load: got valid=%b busy=%b want 0 1", s1_valid, s1_busy); end
        total++; if (lat !== 1858 || result_code !== 8'd74) begin bad++; $display("FAIL accept_start_result: got lat=%0d code=%0d want 1858 74", lat, result_code); end
        accept(v);
    endtask

    task automatic test_rst_mid_match();
        logic v;
        int   seen;
        canvas_from_tmpl(0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (1500) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (busy !== 1'b0 || tmpl_rd_en !== 1'b0) begin bad++; $display("FAIL rst_abort: got busy=%b ten=%b want 0 0", busy, tmpl_rd_en); end
        seen = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (result_valid) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL rst_no_result: got %0d valid cycles want 0", seen); end
        canvas_from_tmpl(1);
        run(0, 1'b0);
        total++; if (lat !== 1858 || result_code !== 8'd66 || result_dist !== 11'd0) begin bad++; $display("FAIL rst_recover: got lat=%0d code=%0d dist=%0d want 1858 66 0", lat, result_code, result_dist); end
        accept(v);
    endtask

    initial begin
        init_tmpl();
        canvas_clear();
        test_reset();
        test_template0();
        test_template3_flipped();
        test_tie();
        test_blank_and_reject();
        test_handshake_and_mid_start();
        test_restart_in_done();
        test_rst_mid_match();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
